// File: rtl/usb_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : usb_tx_pkg
//  Purpose  : Shared state encoding and CRC-16 constants for the USB transmit
//             sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package usb_tx_pkg;

  // Sequencer states; CRC2 is only reachable with 8-bit beats
  typedef enum logic [2:0] {
    IDLE = 3'b000,
    DATA = 3'b010,
    CRC1 = 3'b001,
    CRC2 = 3'b011
  } state_t;

  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

endpackage
`default_nettype wire

// File: rtl/usb_crc16_byte.sv
`default_nettype none
// ============================================================================
//  Module   : usb_crc16_byte
//  Purpose  : Combinational one-byte update of a reflected CRC-16 (0xA001),
//             bits consumed LSB first.
//  Revision : 1.0 - initial release
// ============================================================================
module usb_crc16_byte
  import usb_tx_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  byte_in,
  output logic [15:0] crc_out
);

  // Eight shift/xor steps, one per input bit, starting with bit 0
  always_comb begin
    logic [15:0] c;
    c = crc_in ^ {8'h00, byte_in};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) c = (c >> 1) ^ CRC16_POLY_REFL;
      else      c = c >> 1;
    end
    crc_out = c;
  end

endmodule
`default_nettype wire

// File: rtl/usb_tx_seq.sv
`default_nettype none
// ============================================================================
//  Module   : usb_tx_seq
//  Purpose  : Packet transmit sequencer: passes len payload beats through and
//             appends an inverted CRC-16 trailer. Optional feature macro:
//             USB_TX_CRC_EN (builds the CRC logic and trailer states).
//  Revision : 1.0 - initial release
// ============================================================================
module usb_tx_seq
  import usb_tx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 6,
  parameter int HIST_DEPTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  send_data,
  input  logic [LEN_W-1:0]      len,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  input  logic                  tx_ready,
  output logic                  tx_valid,
  output logic [DATA_W-1:0]     tx_data,
  output logic                  tx_last,
  output logic                  busy,
  output logic [HIST_DEPTH-1:0] buff
);

  state_t           state;
  logic [LEN_W-1:0] count;
  logic             fire;

`ifdef USB_TX_CRC_EN
  logic [15:0] crc;
  logic [15:0] crc_nxt;

  if (DATA_W == 8) begin : g_crc8
    usb_crc16_byte u_crc_lo (
      .crc_in  (crc),
      .byte_in (in_data[7:0]),
      .crc_out (crc_nxt)
    );
  end else begin : g_crc16
    logic [15:0] crc_mid;
    // Low byte goes through the CRC first
    usb_crc16_byte u_crc_lo (
      .crc_in  (crc),
      .byte_in (in_data[7:0]),
      .crc_out (crc_mid)
    );
    usb_crc16_byte u_crc_hi (
      .crc_in  (crc_mid),
      .byte_in (in_data[DATA_W-1:8]),
      .crc_out (crc_nxt)
    );
  end
`endif

  assign busy = (state != IDLE);
  assign fire = tx_valid & tx_ready;

  // Output decode: payload is a straight pass-through, trailer comes from the CRC register
  always_comb begin
    tx_valid = 1'b0;
    in_ready = 1'b0;
    tx_data  = '0;
    tx_last  = 1'b0;
    case (state)
      DATA: begin
        tx_valid = in_valid;
        in_ready = tx_ready;
        tx_data  = in_data;
`ifndef USB_TX_CRC_EN
        tx_last  = in_valid && (count == LEN_W'(1));
`endif
      end
`ifdef USB_TX_CRC_EN
      CRC1: begin
        tx_valid = 1'b1;
        tx_data  = DATA_W'(~crc);
        tx_last  = (DATA_W != 8);
      end
      CRC2: begin
        tx_valid = 1'b1;
        tx_data  = DATA_W'((~crc) >> 8);
        tx_last  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Sequencer state, beat counter, CRC accumulator and transfer history
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      buff  <= '0;
`ifdef USB_TX_CRC_EN
      crc   <= CRC16_INIT;
`endif
    end else begin
      buff <= {buff[HIST_DEPTH-2:0], fire};
      case (state)
        IDLE: begin
          if (send_data) begin
`ifdef USB_TX_CRC_EN
            crc <= CRC16_INIT;
            if (len != '0) begin
              state <= DATA;
              count <= len;
            end else begin
              state <= CRC1;
            end
`else
            if (len != '0) begin
              state <= DATA;
              count <= len;
            end
`endif
          end
        end
        DATA: begin
          if (fire) begin
            count <= count - LEN_W'(1);
`ifdef USB_TX_CRC_EN
            crc   <= crc_nxt;
            if (count == LEN_W'(1)) state <= CRC1;
`else
            if (count == LEN_W'(1)) state <= IDLE;
`endif
          end
        end
`ifdef USB_TX_CRC_EN
        CRC1: begin
          if (tx_ready) state <= (DATA_W == 8) ? CRC2 : IDLE;
        end
        CRC2: begin
          if (tx_ready) state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
